// File: rtl/bigmul_io_pkg.sv
// rtl/bigmul_io_pkg.sv - shared types, labels and helpers for the big-number multiplier I/O blocks
package bigmul_io_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_CALC,
        ST_SHOW
    } state_t;

    localparam logic [15:0] LBL_IN     = "IN";
    localparam logic [23:0] LBL_RES    = "RES";
    localparam logic [23:0] LBL_ERR    = "ERR";
    localparam logic [7:0]  ASCII_ZERO = 8'h30;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/page_slot_mux.sv
// rtl/page_slot_mux.sv - selects the word behind a display slot on the current page, one-cycle registered
module page_slot_mux
    import bigmul_io_pkg::*;
#(
    parameter int MAXWORDS = 64,
    parameter int NSLOT    = 44
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [MAXWORDS*WORD_W-1:0]   words,
    input  logic [15:0]                  len,
    input  logic [7:0]                   page,
    input  logic [5:0]                   number,
    output logic                         valid,
    output logic [WORD_W-1:0]            value
);

    logic [31:0] w;
    logic        hit;

    // Slots are numbered from 1, so slot 0 and slots past NSLOT never hit.
    always_comb begin
        w   = 32'(page) * 32'(NSLOT) + 32'(number) - 32'd1;
        hit = (number != 6'd0) && (32'(number) <= 32'(NSLOT)) && (w < 32'(len));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= 1'b0;
            value <= '0;
        end else if (hit) begin
            valid <= 1'b1;
            value <= words[w*WORD_W +: WORD_W];
        end else begin
            valid <= 1'b0;
            value <= '0;
        end
    end

endmodule

// File: rtl/io_bigmul_pager.sv
// rtl/io_bigmul_pager.sv - touchscreen operand loader, multiplier launcher and paged result viewer
module io_bigmul_pager
    import bigmul_io_pkg::*;
#(
    parameter int  OPW     = 1024,
    parameter int  NUM_OPS = 2,
    parameter int  NSLOT   = 44,
    parameter int  TIMEOUT = 65535,
    localparam int WORDS   = OPW / WORD_W,
    localparam int RESW    = 2 * OPW,
    localparam int RWORDS  = RESW / WORD_W,
    localparam int SELW    = $clog2(NUM_OPS + 1)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    input  logic [31:0]            in_value,
    input  logic [SELW-1:0]        view_sel,
    input  logic                   go,
    input  logic                   clr,
    input  logic                   page_up,
    input  logic                   page_dn,
    output logic [NUM_OPS*OPW-1:0] op_flat,
    output logic                   mul_start,
    input  logic                   mul_done,
    input  logic [RESW-1:0]        mul_result,
    input  logic [5:0]             display_number,
    output logic                   display_valid,
    output logic [39:0]            display_name,
    output logic [31:0]            display_value,
    output logic                   busy,
    output logic                   err,
    output logic [NUM_OPS-1:0]     op_full,
    output logic [7:0]             page
);

    localparam int PAGES_OP  = ceil_div(WORDS, NSLOT);
    localparam int PAGES_RES = ceil_div(RWORDS, NSLOT);
    localparam int WPW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNTW      = $clog2(TIMEOUT + 1);

    state_t          state, state_n;
    logic [OPW-1:0]  ops [NUM_OPS];
    logic [WPW-1:0]  wp  [NUM_OPS];
    logic [RESW-1:0] product;
    logic [CNTW-1:0] cnt;
    logic [SELW-1:0] view_prev;
    logic            view_is_op, view_is_res;
    int              sel_idx;
    logic            wr_en, clr_en, launch, capture, tmo;
    logic [RESW-1:0] view_words;
    logic [15:0]     view_len;
    logic [7:0]      page_last;

    always_comb begin
        view_is_op  = (view_sel < SELW'(NUM_OPS));
        view_is_res = (view_sel == SELW'(NUM_OPS));
        sel_idx     = view_is_op ? int'(view_sel) : 0;
        page_last   = view_is_res ? 8'(PAGES_RES - 1) : 8'(PAGES_OP - 1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_LOAD;
        else         state <= state_n;
    end

    // SHOW behaves like LOAD for operand edits; any edit simply drops back to LOAD.
    always_comb begin
        state_n = state;
        wr_en   = 1'b0;
        clr_en  = 1'b0;
        launch  = 1'b0;
        capture = 1'b0;
        tmo     = 1'b0;
        case (state)
            ST_LOAD, ST_SHOW: begin
                if (clr && view_is_op)           clr_en = 1'b1;
                else if (in_valid && view_is_op) wr_en  = 1'b1;
                if (go) begin
                    launch  = 1'b1;
                    state_n = ST_CALC;
                end else if (state == ST_SHOW && (in_valid || clr)) begin
                    state_n = ST_LOAD;
                end
            end
            ST_CALC: begin
                if (mul_done) begin
                    capture = 1'b1;
                    state_n = ST_SHOW;
                end else if (cnt == CNTW'(TIMEOUT)) begin
                    tmo     = 1'b1;
                    state_n = ST_LOAD;
                end
            end
            default: state_n = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < NUM_OPS; k++) begin
                ops[k] <= '0;
                wp[k]  <= '0;
            end
            op_full   <= '0;
            product   <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            mul_start <= 1'b0;
        end else begin
            mul_start <= launch;
            if (launch) begin
                cnt <= '0;
                err <= 1'b0;
            end else if (state == ST_CALC) begin
                cnt <= cnt + 1'b1;
            end
            if (tmo)     err     <= 1'b1;
            if (capture) product <= mul_result;
            for (int k = 0; k < NUM_OPS; k++) begin
                if (clr_en && sel_idx == k) begin
                    ops[k]     <= '0;
                    wp[k]      <= '0;
                    op_full[k] <= 1'b0;
                end else if (wr_en && sel_idx == k) begin
                    ops[k][wp[k]*WORD_W +: WORD_W] <= in_value;
                    if (wp[k] == WPW'(WORDS - 1)) begin
                        wp[k]      <= '0;
                        op_full[k] <= 1'b1;
                    end else begin
                        wp[k] <= wp[k] + 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_flat
        assign op_flat[g*OPW +: OPW] = ops[g];
    end

    assign busy = (state == ST_CALC);

    // A view switch wins over page pulses so the new view always opens on page 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            page      <= '0;
            view_prev <= '0;
        end else begin
            view_prev <= view_sel;
            if (view_sel != view_prev)                          page <= '0;
            else if (page_up && !page_dn && page < page_last)   page <= page + 8'd1;
            else if (page_dn && !page_up && page != 8'd0)       page <= page - 8'd1;
        end
    end

    always_comb begin
        view_words = '0;
        view_len   = '0;
        if (view_is_res) begin
            view_words = product;
            view_len   = 16'(RWORDS);
        end else if (view_is_op) begin
            view_words[OPW-1:0] = ops[sel_idx];
            view_len            = 16'(WORDS);
        end
    end

    page_slot_mux #(
        .MAXWORDS (RWORDS),
        .NSLOT    (NSLOT)
    ) u_slot_mux (
        .clk    (clk),
        .resetn (resetn),
        .words  (view_words),
        .len    (view_len),
        .page   (page),
        .number (display_number),
        .valid  (display_valid),
        .value  (display_value)
    );

    always_ff @(posedge clk) begin
        if (!resetn)          display_name <= {16'h0, LBL_IN, ASCII_ZERO + 8'd1};
        else if (view_is_res) display_name <= {16'h0, err ? LBL_ERR : LBL_RES};
        else                  display_name <= {16'h0, LBL_IN, ASCII_ZERO + 8'(view_sel) + 8'd1};
    end

endmodule

// File: doc/io_bigmul_pager.md
Name: io_bigmul_pager

Overview:
Parametrised touchscreen I/O controller for the big-number multiplier datapath, sitting between lcd_module and a multiplier core.
- Loads N operands word-by-word, each operand with its own write pointer.
- Launches the multiplier with a start/done handshake and timeout, then latches the product.
- Pages any operand or the full product across the NSLOT display slots, so results wider than the screen are fully viewable.

Parameters:
OPW, 1024, operand width in bits (multiple of 32)
NUM_OPS, 2, number of operands (2..9)
NSLOT, 44, touchscreen display slots
TIMEOUT, 65535, max cycles to wait for mul_done
Derived (localparam): WORDS=OPW/32, RESW=2*OPW, RWORDS=RESW/32, SELW=$clog2(NUM_OPS+1), PAGES_OP=ceil(WORDS/NSLOT), PAGES_RES=ceil(RWORDS/NSLOT)

Ports:
clk  in  1  clock
resetn  in  1  synchronous reset, active-low
in_valid  in  1  one-cycle pulse, touchscreen word entered
in_value  in  32  entered word
view_sel  in  SELW  0..NUM_OPS-1 = operand k (write target and view); NUM_OPS = product view
go  in  1  pulse, start multiplication
clr  in  1  pulse, clear operand view_sel and its pointer
page_up  in  1  pulse, next display page
page_dn  in  1  pulse, previous display page
op_flat  out  NUM_OPS*OPW  operands; operand k at [k*OPW +: OPW]
mul_start  out  1  one-cycle start pulse to multiplier
mul_done  in  1  multiplier result valid (pulse or level)
mul_result  in  RESW  multiplier product
display_number  in  6  slot requested by lcd_module (1..NSLOT)
display_valid  out  1  slot data valid
display_name  out  40  slot label
display_value  out  32  slot word
busy  out  1  high in CALC
err  out  1  sticky timeout flag
op_full  out  NUM_OPS  bit k set once operand k has received WORDS words
page  out  8  current page index

Behaviour:
Reset:
- Synchronous, resetn low at posedge: all operands, product, pointers, page, op_full and err go to 0.
- mul_start=0, busy=0, display_valid=0, display_value=0, display_name="IN1", state=LOAD.
- Reset in CALC abandons the operation; a later mul_done is ignored.

FSM (LOAD, CALC, SHOW):
- LOAD, in_valid, view_sel<NUM_OPS: write word wp[k] of operand k (bits wp*32 +: 32); wp[k] increments and wraps WORDS-1 -> 0; wrap sets op_full[k].
- LOAD, in_valid, view_sel==NUM_OPS: ignored.
- LOAD, clr: zero operand view_sel, wp=0, op_full bit cleared. clr with in_valid in the same cycle: clr wins.
- LOAD, go -> CALC: mul_start=1 for exactly the next cycle; timeout counter=0; busy=1. in_valid in the same cycle as go is still written before mul_start.
- CALC: in_valid, clr and go are ignored; counter increments.
  - mul_done -> latch mul_result, go to SHOW, busy=0.
  - counter==TIMEOUT without done -> err=1, back to LOAD, product unchanged.
- SHOW: go re-launches (-> CALC). in_valid or clr returns to LOAD and applies the action in that cycle. err clears on the next go.

Paging:
- Any change of view_sel resets page to 0; page pulses in that cycle are ignored.
- page_up saturates at last page of the view (PAGES_OP-1 or PAGES_RES-1); page_dn saturates at 0; both together: no change.

Display (registered, 1-cycle latency from display_number):
- Word index w = page*NSLOT + display_number-1.
- display_number in 1..NSLOT and w < view length (WORDS or RWORDS): display_valid=1, display_value = word w.
- Otherwise display_valid=0, display_value=0.
- Product view reads the latched product, not mul_result.
- display_name = "IN"+ASCII(k+1) for operand k, "RES" for the product view, "ERR" while err=1 in product view; padded to 40 bits with leading zeros.

Decomposition:
- Package bigmul_io_pkg: state encoding (LOAD/CALC/SHOW), ASCII label constants, word-width constant 32, helper function ceil_div.
- One natural sub-module: page_slot_mux (view words + page + display_number -> registered valid/value), reusable by later large-number display blocks.

Test Plan:
- OPW=128, NUM_OPS=2: 4 in_valid on op0 with 1,2,3,4 -> op_flat[127:0]=0x4_3_2_1 word-order, op_full=01; 5th word 9 overwrites word0 (wrap).
- go with stub multiplier returning done after 10 cycles, result 0xABCD -> mul_start high exactly 1 cycle, busy 11 cycles, SHOW, product view slot1 = 0x0000ABCD, name "RES".
- OPW=1024, NSLOT=44, product view: slot1 on page0 = word0; page_up -> slot1 = word44; page_up to page 1 saturates (PAGES_RES=2); slot 21 on page1 (w=64) -> display_valid=0.
- TIMEOUT=20, mul_done never -> err=1 after 20 cycles, state LOAD, product view name "ERR"; next go clears err.
- resetn low during CALC, then late mul_done -> no capture, all outputs at reset values.
- clr and in_valid in same cycle on op1 -> op1=0, wp=0, op_full[1]=0.
